// File: rtl/mem_responder.sv
// mem_responder: four-phase MAR/MDR memory responder with configurable wait states
module mem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              R_W,
    input  logic              memEn,
    output logic [DATA_W-1:0] dataOut,
    output logic              MFC,
    output logic              busy,
    output logic              addrErr
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
    localparam bit NO_WAIT = WAIT_CYCLES == 0;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    state_t state, state_nx;
    logic [3:0] cnt;
    logic [ADDR_W-1:0] lat_addr, acc_addr;
    logic [DATA_W-1:0] lat_data, acc_data;
    logic lat_rw, acc_rw, capture, access, in_range;
    logic [IW-1:0] idx;
    logic [DATA_W-1:0] mem [DEPTH];
    // With no wait states the access uses the live inputs on the capture edge
    always_comb begin
        capture  = state == S_IDLE && memEn;
        access   = (capture && NO_WAIT) || (state == S_WAIT && cnt == 4'd0);
        acc_addr = state == S_IDLE ? address : lat_addr;
        acc_data = state == S_IDLE ? dataIn : lat_data;
        acc_rw   = state == S_IDLE ? R_W : lat_rw;
        in_range = 32'(acc_addr) < 32'(DEPTH);
        idx      = acc_addr[IW-1:0];
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= S_IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (memEn) state_nx = NO_WAIT ? S_DONE : S_WAIT;
            S_WAIT:  if (cnt == 4'd0) state_nx = S_DONE;
            S_DONE:  if (!memEn) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end
    always_comb begin
        MFC  = state == S_DONE;
        busy = state != S_IDLE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= 4'd0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_rw   <= 1'b0;
            dataOut  <= '0;
            addrErr  <= 1'b0;
        end else begin
            if (capture) begin
                lat_addr <= address;
                lat_data <= dataIn;
                lat_rw   <= R_W;
                cnt      <= CNT_INIT;
                addrErr  <= 1'b0;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                addrErr <= !in_range;
                if (acc_rw) dataOut <= in_range ? mem[idx] : '0;
            end
        end
    end
    // Array has no reset so its contents survive a reset
    always_ff @(posedge clk)
        if (access && !acc_rw && in_range) mem[idx] <= acc_data;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: random and directed handshakes on 3-wait and 0-wait responders
module tb_mem_responder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [15:0] address = '0;
    logic [15:0] dataIn = '0;
    logic R_W = 1'b0;
    logic [1:0] en = '0;
    logic [15:0] dout0, dout1;
    logic [1:0] mfc, busy, aerr;
    logic [15:0] mdl [2][256];
    logic [15:0] exp_dout [2];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_responder #(.WAIT_CYCLES(3)) u3 (
        .clk(clk), .reset(reset), .address(address), .dataIn(dataIn), .R_W(R_W),
        .memEn(en[0]), .dataOut(dout0), .MFC(mfc[0]), .busy(busy[0]), .addrErr(aerr[0])
    );
    mem_responder #(.WAIT_CYCLES(0)) u0 (
        .clk(clk), .reset(reset), .address(address), .dataIn(dataIn), .R_W(R_W),
        .memEn(en[1]), .dataOut(dout1), .MFC(mfc[1]), .busy(busy[1]), .addrErr(aerr[1])
    );

    function automatic int wc(input int d);
        return d == 0 ? 3 : 0;
    endfunction

    function automatic logic [15:0] get_dout(input int d);
        return d == 0 ? dout0 : dout1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full four-phase transaction; inputs are disturbed right after capture
    task automatic xfer(input int d, input logic rw, input logic [15:0] a,
                        input logic [15:0] wd, input bit early_drop);
        int n;
        address = a;
        dataIn  = wd;
        R_W     = rw;
        en[d]   = 1'b1;
        @(posedge clk); #1;
        address = a + 16'd1;
        dataIn  = 16'hFFFF;
        R_W     = ~rw;
        chk("busy_capture", 32'(busy[d]), 32'd1);
        if (early_drop) en[d] = 1'b0;
        if (a < 16'd256) begin
            if (rw) exp_dout[d] = mdl[d][a[7:0]];
            else mdl[d][a[7:0]] = wd;
        end else if (rw) begin
            exp_dout[d] = '0;
        end
        n = 0;
        while (!mfc[d] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(wc(d)));
        chk("mfc_up", 32'(mfc[d]), 32'd1);
        chk("busy_done", 32'(busy[d]), 32'd1);
        chk("dataOut", 32'(get_dout(d)), 32'(exp_dout[d]));
        chk("addrErr", 32'(aerr[d]), 32'(a >= 16'd256));
        en[d] = 1'b0;
        @(posedge clk); #1;
        chk("mfc_down", 32'(mfc[d]), 32'd0);
        chk("busy_down", 32'(busy[d]), 32'd0);
        chk("dataOut_hold", 32'(get_dout(d)), 32'(exp_dout[d]));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_dout[0] = '0;
        exp_dout[1] = '0;
        for (int d = 0; d < 2; d++) begin
            chk("rst_mfc", 32'(mfc[d]), 32'd0);
            chk("rst_busy", 32'(busy[d]), 32'd0);
            chk("rst_addrErr", 32'(aerr[d]), 32'd0);
            chk("rst_dataOut", 32'(get_dout(d)), 32'd0);
        end
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++)
                xfer(d, 1'b0, 16'(i), 16'($urandom), 1'b0);
        xfer(0, 1'b0, 16'd5, 16'hBEEF, 1'b0);
        xfer(0, 1'b1, 16'd5, 16'h0000, 1'b0);
        xfer(0, 1'b0, 16'd10, 16'h1234, 1'b0);
        xfer(0, 1'b1, 16'd10, 16'h0000, 1'b0);
        xfer(0, 1'b1, 16'd300, 16'h0000, 1'b0);
        xfer(0, 1'b0, 16'd300, 16'hAAAA, 1'b0);
        xfer(0, 1'b1, 16'd44, 16'h0000, 1'b0);
        xfer(0, 1'b0, 16'd7, 16'h00FF, 1'b0);
        xfer(0, 1'b1, 16'd7, 16'h0000, 1'b0);
        xfer(0, 1'b1, 16'd8, 16'h0000, 1'b0);
        xfer(0, 1'b1, 16'd20, 16'h0000, 1'b1);
        // Write abandoned by a reset pulse while waiting
        xfer(0, 1'b0, 16'd3, 16'h0001, 1'b0);
        address = 16'd3;
        dataIn  = 16'h5555;
        R_W     = 1'b0;
        en[0]   = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("midrst_mfc", 32'(mfc[0]), 32'd0);
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        en[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_dout[0] = '0;
        exp_dout[1] = '0;
        chk("midrst_dataOut", 32'(dout0), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_mfc", 32'(mfc[0]), 32'd0);
        end
        xfer(0, 1'b1, 16'd3, 16'h0000, 1'b0);
        xfer(1, 1'b0, 16'd12, 16'hC0DE, 1'b0);
        xfer(1, 1'b1, 16'd12, 16'h0000, 1'b0);
        xfer(1, 1'b1, 16'd300, 16'h0000, 1'b0);
        xfer(1, 1'b1, 16'd12, 16'h0000, 1'b1);
        for (int k = 0; k < 80; k++)
            xfer(int'($urandom_range(0, 1)), 1'($urandom), 16'($urandom_range(0, 299)),
                 16'($urandom), $urandom_range(0, 3) == 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the processor's MAR/MDR memory handshake. It accepts read or write requests from an initiator, such as the instruction-fetch or load/store controller. It inserts a configurable number of wait states, performs the access on an internal word array, and signals completion with MFC (memory function complete). Requests use a four-phase protocol: the initiator raises memEn, the responder raises MFC, the initiator drops memEn, and the responder drops MFC.

Parameters:
DATA_W, 16, data word width
ADDR_W, 16, address width
DEPTH, 256, number of implemented words; valid addresses are 0..DEPTH-1
WAIT_CYCLES, 3, wait states between request capture and completion (0..15)

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset
address  input  ADDR_W  word address from MAR
dataIn  input  DATA_W  write data from MDR
R_W  input  1  1 = read, 0 = write
memEn  input  1  request strobe; held high by the initiator until MFC is seen
dataOut  output  DATA_W  read data to MDR
MFC  output  1  access complete; level signal
busy  output  1  high when a request is captured and not yet released
addrErr  output  1  the completed access targeted address >= DEPTH

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - MFC=0, busy=0, addrErr=0, dataOut=0, wait counter=0.
  - The memory array is NOT cleared; its contents persist across reset.
- States: IDLE, WAIT, DONE.
- IDLE:
  - On a rising edge with memEn=1, latch address, R_W and dataIn into internal registers, and set busy=1.
  - If WAIT_CYCLES>0, load the counter with WAIT_CYCLES-1 and go to WAIT.
  - If WAIT_CYCLES=0, perform the access on this same edge and go directly to DONE.
- WAIT:
  - Decrement the counter each edge.
  - On the edge where the counter is 0, perform the access and go to DONE.
  - Changes to address, dataIn or R_W during WAIT are ignored; only the latched values are used.
- The access:
  - Read: dataOut <= mem[latched address].
  - Write: mem[latched address] <= latched dataIn; dataOut is unchanged.
  - Out of range (latched address >= DEPTH): no array write; a read returns dataOut=0; addrErr=1.
  - In range: addrErr=0.
  - MFC goes 1 on the same edge the access is performed.
- DONE:
  - MFC=1 and busy=1 are held.
  - dataOut and addrErr are held.
  - On the edge where memEn=0, go to IDLE with MFC=0 and busy=0.
  - dataOut keeps its last read value until the next read completes.
- Latency: if memEn is first sampled high at edge N, MFC is high after edge N+WAIT_CYCLES.
  - WAIT_CYCLES=3: MFC after N+3.
  - WAIT_CYCLES=0: MFC after N.
- Minimum cycle between back-to-back requests:
  - MFC is low for at least 1 clock.
  - memEn re-asserted while in IDLE is captured on the next edge.
- memEn dropped before MFC (protocol violation): the access still completes. DONE is entered and immediately exits to IDLE on the next edge, because memEn is already 0.
- addrErr is cleared when the next request is captured in IDLE.
- Reset mid-operation:
  - Any pending write in WAIT is abandoned; the array is not modified.
  - A write already performed on the completion edge stays.
- Clocks on which memEn=0 and the state is IDLE cause no state change.

Test Plan:
1. Reset then read: reset low for 2 clocks; preload mem[5]=16'hBEEF; memEn=1, R_W=1, address=5 -> MFC rises exactly 3 edges after capture, dataOut=16'hBEEF, addrErr=0; drop memEn -> MFC=0 and busy=0 after the next edge.
2. Write then read back: write 16'h1234 to address 10, complete the handshake, then read address 10 -> dataOut=16'h1234; in the write phase dataOut holds its previous value.
3. Out of range: read address 300 with DEPTH=256 -> MFC after 3 edges, dataOut=0, addrErr=1; write 16'hAAAA to 300, then read 300 mod 256 = 44 -> mem[44] unchanged.
4. Input changes during WAIT: capture a write of 16'h00FF to address 7, then change address to 8 and dataIn to 16'hFFFF during WAIT -> mem[7]=16'h00FF and mem[8] unchanged.
5. Reset mid-WAIT: capture a write of 16'h5555 to address 3 (old value 16'h0001), pulse reset low 1 cycle later -> MFC never rises, mem[3]=16'h0001, state IDLE; the next read of 3 returns 16'h0001.
6. Zero wait and back-to-back: WAIT_CYCLES=0; memEn held high across two requests with a 1-cycle low gap -> each MFC rises on the capture edge, MFC low at least 1 clock between requests, both reads return the correct data.
